// File: rtl/rtc_pkg.sv
// ---------------------------------------------------------------------------
// rtc_pkg
// Shared types, constants and helpers for the real-time clock with alarm bank.
//   fsm_state_e : alarm state machine states (IDLE / RING / SNOOZE)
//   bcd8_t      : two-digit packed BCD value {tens, ones}
//   MAX_HH      : largest legal internal hour (23)
//   MAX_MS      : largest legal minute/second (59)
//   bcd_valid() : both nibbles are decimal digits and the value is <= max
//   bcd_inc()   : increment a two-digit BCD value (no wrap handling)
//   to12h()     : map a 24-hour BCD hour to {12-hour BCD hour, pm}
// ---------------------------------------------------------------------------
package rtc_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RING   = 2'd1,
      SNOOZE = 2'd2
   } fsm_state_e;

   typedef logic [7:0] bcd8_t;

   localparam bcd8_t MAX_HH = 8'h23;
   localparam bcd8_t MAX_MS = 8'h59;

   // For well-formed BCD, the binary ordering of the byte matches the
   // decimal ordering, so a plain compare against the BCD maximum works.
   function automatic logic bcd_valid(input bcd8_t val, input bcd8_t max);
      return (val[7:4] <= 4'd9) && (val[3:0] <= 4'd9) && (val <= max);
   endfunction

   function automatic bcd8_t bcd_inc(input bcd8_t val);
      bcd8_t res;
      if (val[3:0] == 4'd9) begin
         res = {val[7:4] + 4'd1, 4'd0};
      end else begin
         res = {val[7:4], val[3:0] + 4'd1};
      end
      return res;
   endfunction

   // Goes through binary because subtracting 12 directly in BCD needs a
   // borrow fix-up for hours 20..23.
   function automatic logic [8:0] to12h(input bcd8_t hh);
      logic [4:0] bin;
      logic [4:0] h12;
      logic       is_pm;
      bin   = 5'(hh[7:4]) * 5'd10 + 5'(hh[3:0]);
      is_pm = (bin >= 5'd12);
      if (bin == 5'd0) begin
         h12 = 5'd12;
      end else if (bin > 5'd12) begin
         h12 = bin - 5'd12;
      end else begin
         h12 = bin;
      end
      if (h12 >= 5'd10) begin
         return {4'd1, 4'(h12 - 5'd10), is_pm};
      end
      return {4'd0, 4'(h12), is_pm};
   endfunction

endpackage

// File: rtl/rtc_alarm_fsm.sv
// ---------------------------------------------------------------------------
// rtc_alarm_fsm
// Ring / snooze / stop controller for the alarm bank.
//   clock, reset       : system clock, asynchronous active-low reset
//   minute_tick        : one-cycle pulse per minute rollover
//   match, match_id    : an enabled alarm slot hit (winning slot number)
//   stop, snooze       : one-cycle user requests; stop beats snooze
//   ringing, ring_id   : registered alarm output and the slot responsible
// ---------------------------------------------------------------------------
module rtc_alarm_fsm
   import rtc_pkg::*;
#(
   parameter int SNOOZE_MIN = 5,
   parameter int RING_MIN   = 2,
   parameter int IDX_W      = 2
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             minute_tick,
   input  logic             match,
   input  logic [IDX_W-1:0] match_id,
   input  logic             stop,
   input  logic             snooze,
   output logic             ringing,
   output logic [IDX_W-1:0] ring_id
);

   fsm_state_e       state_q, state_d;
   logic [5:0]       min_cnt_q, min_cnt_d;
   logic [5:0]       min_next;
   logic [IDX_W-1:0] ring_id_q, ring_id_d;
   logic             ringing_q, ringing_d;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         min_cnt_q <= '0;
         ring_id_q <= '0;
         ringing_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         min_cnt_q <= min_cnt_d;
         ring_id_q <= ring_id_d;
         ringing_q <= ringing_d;
      end
   end

   // The minute counter restarts on every entry to RING or SNOOZE, so the
   // rollover that triggered a match is never counted against the ring time.
   always_comb begin
      state_d   = state_q;
      min_cnt_d = min_cnt_q;
      ring_id_d = ring_id_q;
      min_next  = min_cnt_q + 6'd1;
      case (state_q)
         IDLE: begin
            if (match) begin
               state_d   = RING;
               min_cnt_d = '0;
               ring_id_d = match_id;
            end
         end
         RING: begin
            if (stop) begin
               state_d = IDLE;
            end else if (snooze) begin
               state_d   = SNOOZE;
               min_cnt_d = '0;
            end else if (minute_tick) begin
               if (min_next == 6'(RING_MIN)) begin
                  state_d = IDLE;
               end else begin
                  min_cnt_d = min_next;
               end
            end
         end
         SNOOZE: begin
            if (stop) begin
               state_d = IDLE;
            end else if (match) begin
               state_d   = RING;
               min_cnt_d = '0;
               ring_id_d = match_id;
            end else if (minute_tick) begin
               if (min_next == 6'(SNOOZE_MIN)) begin
                  state_d   = RING;
                  min_cnt_d = '0;
               end else begin
                  min_cnt_d = min_next;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_comb begin
      ringing_d = (state_d == RING);
   end

   assign ringing = ringing_q;
   assign ring_id = ring_id_q;

endmodule

// File: rtl/rtc_alarm_bank.sv
// ---------------------------------------------------------------------------
// rtc_alarm_bank
// Real-time clock (24-hour BCD internally) with a bank of alarm slots.
//   clock, reset            : system clock, asynchronous active-low reset
//   mode_24h                : 1 = 24-hour display, 0 = 12-hour display
//   set_valid, set_hh/mm/ss : time load strobe and BCD time (24-hour form)
//   set_err                 : one-cycle pulse when a load or alarm write
//                             carries invalid BCD
//   alm_wr, alm_idx, alm_hh, alm_mm, alm_en : alarm slot write port
//   snooze, stop            : one-cycle user requests
//   h/m/s tens/ones, pm     : registered display digits and pm flag
//   ringing, ring_id        : alarm output and responsible slot
// ---------------------------------------------------------------------------
module rtc_alarm_bank
   import rtc_pkg::*;
#(
   parameter  int TICK_DIV   = 100_000_000,
   parameter  int NUM_ALARMS = 4,
   parameter  int SNOOZE_MIN = 5,
   parameter  int RING_MIN   = 2,
   localparam int IDX_W      = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             mode_24h,
   input  logic             set_valid,
   input  logic [7:0]       set_hh,
   input  logic [7:0]       set_mm,
   input  logic [7:0]       set_ss,
   output logic             set_err,
   input  logic             alm_wr,
   input  logic [IDX_W-1:0] alm_idx,
   input  logic [7:0]       alm_hh,
   input  logic [7:0]       alm_mm,
   input  logic             alm_en,
   input  logic             snooze,
   input  logic             stop,
   output logic [3:0]       h_tens,
   output logic [3:0]       h_ones,
   output logic [3:0]       m_tens,
   output logic [3:0]       m_ones,
   output logic [3:0]       s_tens,
   output logic [3:0]       s_ones,
   output logic             pm,
   output logic             ringing,
   output logic [IDX_W-1:0] ring_id
);

   localparam int PRESC_W = $clog2(TICK_DIV);

   logic [PRESC_W-1:0]  presc_q, presc_d;
   bcd8_t               hh_q, hh_d, mm_q, mm_d, ss_q, ss_d;
   bcd8_t               alm_hh_q [NUM_ALARMS];
   bcd8_t               alm_hh_d [NUM_ALARMS];
   bcd8_t               alm_mm_q [NUM_ALARMS];
   bcd8_t               alm_mm_d [NUM_ALARMS];
   logic [NUM_ALARMS-1:0] alm_en_q, alm_en_d;
   logic                set_err_q, set_err_d;
   bcd8_t               disp_hh_q, disp_hh_d;
   logic                pm_q, pm_d;
   logic                match_q, match_d;
   logic [IDX_W-1:0]    match_id_q, match_id_d;
   logic                minute_q, minute_d;

   logic                tick, set_ok, load, alm_ok, alm_hit;
   logic [8:0]          hh12;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         presc_q    <= '0;
         hh_q       <= '0;
         mm_q       <= '0;
         ss_q       <= '0;
         alm_hh_q   <= '{default: '0};
         alm_mm_q   <= '{default: '0};
         alm_en_q   <= '0;
         set_err_q  <= 1'b0;
         disp_hh_q  <= '0;
         pm_q       <= 1'b0;
         match_q    <= 1'b0;
         match_id_q <= '0;
         minute_q   <= 1'b0;
      end else begin
         presc_q    <= presc_d;
         hh_q       <= hh_d;
         mm_q       <= mm_d;
         ss_q       <= ss_d;
         alm_hh_q   <= alm_hh_d;
         alm_mm_q   <= alm_mm_d;
         alm_en_q   <= alm_en_d;
         set_err_q  <= set_err_d;
         disp_hh_q  <= disp_hh_d;
         pm_q       <= pm_d;
         match_q    <= match_d;
         match_id_q <= match_id_d;
         minute_q   <= minute_d;
      end
   end

   // Timebase: a valid load wins over a coincident tick and restarts the
   // prescaler; a rejected load leaves timekeeping undisturbed.
   always_comb begin
      tick     = (presc_q == PRESC_W'(TICK_DIV - 1));
      set_ok   = bcd_valid(set_hh, MAX_HH) && bcd_valid(set_mm, MAX_MS) &&
                 bcd_valid(set_ss, MAX_MS);
      load     = set_valid && set_ok;
      presc_d  = (load || tick) ? '0 : presc_q + PRESC_W'(1);
      hh_d     = hh_q;
      mm_d     = mm_q;
      ss_d     = ss_q;
      minute_d = 1'b0;
      if (load) begin
         hh_d = set_hh;
         mm_d = set_mm;
         ss_d = set_ss;
      end else if (tick) begin
         if (ss_q == MAX_MS) begin
            ss_d     = '0;
            minute_d = 1'b1;
            if (mm_q == MAX_MS) begin
               mm_d = '0;
               hh_d = (hh_q == MAX_HH) ? '0 : bcd_inc(hh_q);
            end else begin
               mm_d = bcd_inc(mm_q);
            end
         end else begin
            ss_d = bcd_inc(ss_q);
         end
      end
   end

   // Slot writes land next cycle, so a write coincident with a matching
   // tick is compared against the old slot contents below.
   always_comb begin
      alm_hh_d = alm_hh_q;
      alm_mm_d = alm_mm_q;
      alm_en_d = alm_en_q;
      alm_ok   = bcd_valid(alm_hh, MAX_HH) && bcd_valid(alm_mm, MAX_MS);
      alm_hit  = alm_wr && (32'(alm_idx) < NUM_ALARMS);
      if (alm_hit) begin
         if (alm_ok) begin
            alm_hh_d[alm_idx] = alm_hh;
            alm_mm_d[alm_idx] = alm_mm;
            alm_en_d[alm_idx] = alm_en;
         end else begin
            alm_en_d[alm_idx] = 1'b0;
         end
      end
      set_err_d = (set_valid && !set_ok) || (alm_hit && !alm_ok);
   end

   // Only a tick that rolls the seconds to 00 can match; scanning from the
   // top down lets the lowest matching index overwrite the others.
   always_comb begin
      match_d    = 1'b0;
      match_id_d = '0;
      for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
         if (minute_d && alm_en_q[i] && (alm_hh_q[i] == hh_d) &&
             (alm_mm_q[i] == mm_d)) begin
            match_d    = 1'b1;
            match_id_d = IDX_W'(i);
         end
      end
   end

   // Display hour is mapped from the next time value so the hour digits
   // move on the same edge as the minutes and seconds.
   always_comb begin
      hh12      = to12h(hh_d);
      disp_hh_d = mode_24h ? hh_d : hh12[8:1];
      pm_d      = hh12[0];
   end

   rtc_alarm_fsm #(
      .SNOOZE_MIN (SNOOZE_MIN),
      .RING_MIN   (RING_MIN),
      .IDX_W      (IDX_W)
   ) u_fsm (
      .clock       (clock),
      .reset       (reset),
      .minute_tick (minute_q),
      .match       (match_q),
      .match_id    (match_id_q),
      .stop        (stop),
      .snooze      (snooze),
      .ringing     (ringing),
      .ring_id     (ring_id)
   );

   assign h_tens  = disp_hh_q[7:4];
   assign h_ones  = disp_hh_q[3:0];
   assign m_tens  = mm_q[7:4];
   assign m_ones  = mm_q[3:0];
   assign s_tens  = ss_q[7:4];
   assign s_ones  = ss_q[3:0];
   assign pm      = pm_q;
   assign set_err = set_err_q;

endmodule

// File: tb/tb_rtc_alarm_bank.sv
// ---------------------------------------------------------------------------
// tb_rtc_alarm_bank
// Directed bench for rtc_alarm_bank with a 4-cycle second so that minute
// rollovers, alarm rings, snooze and timeout happen in a few hundred cycles.
// Inputs change and outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_rtc_alarm_bank;

   logic       clock;
   logic       reset;
   logic       mode_24h;
   logic       set_valid;
   logic [7:0] set_hh, set_mm, set_ss;
   logic       set_err;
   logic       alm_wr;
   logic [1:0] alm_idx;
   logic [7:0] alm_hh, alm_mm;
   logic       alm_en;
   logic       snooze, stop;
   logic [3:0] h_tens, h_ones, m_tens, m_ones, s_tens, s_ones;
   logic       pm;
   logic       ringing;
   logic [1:0] ring_id;

   int errors = 0;
   int checks = 0;

   rtc_alarm_bank #(
      .TICK_DIV   (4),
      .NUM_ALARMS (4),
      .SNOOZE_MIN (2),
      .RING_MIN   (1)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .mode_24h  (mode_24h),
      .set_valid (set_valid),
      .set_hh    (set_hh),
      .set_mm    (set_mm),
      .set_ss    (set_ss),
      .set_err   (set_err),
      .alm_wr    (alm_wr),
      .alm_idx   (alm_idx),
      .alm_hh    (alm_hh),
      .alm_mm    (alm_mm),
      .alm_en    (alm_en),
      .snooze    (snooze),
      .stop      (stop),
      .h_tens    (h_tens),
      .h_ones    (h_ones),
      .m_tens    (m_tens),
      .m_ones    (m_ones),
      .s_tens    (s_tens),
      .s_ones    (s_ones),
      .pm        (pm),
      .ringing   (ringing),
      .ring_id   (ring_id)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Safety net in case the sequence below ever stalls.
   initial begin
      #200000;
      $display("[TB] FAIL timeout: simulation did not reach the summary");
      $fatal(1, "[TB] timeout");
   end

   task automatic check_output(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_time(input string tag, input logic [23:0] exp);
      check_output(tag, 32'({h_tens, h_ones, m_tens, m_ones, s_tens, s_ones}),
                   32'(exp));
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic apply_set(input logic [7:0] hh, input logic [7:0] mm,
                            input logic [7:0] ss);
      set_hh    = hh;
      set_mm    = mm;
      set_ss    = ss;
      set_valid = 1'b1;
      @(negedge clock);
      set_valid = 1'b0;
   endtask

   task automatic apply_alarm(input logic [1:0] idx, input logic [7:0] hh,
                              input logic [7:0] mm, input logic en);
      alm_idx = idx;
      alm_hh  = hh;
      alm_mm  = mm;
      alm_en  = en;
      alm_wr  = 1'b1;
      @(negedge clock);
      alm_wr  = 1'b0;
   endtask

   task automatic apply_ctrl(input logic stop_v, input logic snooze_v);
      stop   = stop_v;
      snooze = snooze_v;
      @(negedge clock);
      stop   = 1'b0;
      snooze = 1'b0;
   endtask

   initial begin
      reset     = 1'b0;
      mode_24h  = 1'b0;
      set_valid = 1'b0;
      set_hh    = '0;
      set_mm    = '0;
      set_ss    = '0;
      alm_wr    = 1'b0;
      alm_idx   = '0;
      alm_hh    = '0;
      alm_mm    = '0;
      alm_en    = 1'b0;
      snooze    = 1'b0;
      stop      = 1'b0;

      // Reset and 12-hour display of midnight
      step(2);
      check_output("rst_ringing", 32'(ringing), 32'd0);
      check_output("rst_pm", 32'(pm), 32'd0);
      reset = 1'b1;
      step(1);
      check_time("rst_12h", 24'h120000);
      check_output("rst_pm_12h", 32'(pm), 32'd0);
      check_output("rst_set_err", 32'(set_err), 32'd0);
      check_output("rst_ring_id", 32'(ring_id), 32'd0);

      // Afternoon in 12-hour mode, then flip to 24-hour
      apply_set(8'h13, 8'h05, 8'h09);
      check_time("load_12h", 24'h010509);
      check_output("load_pm", 32'(pm), 32'd1);
      mode_24h = 1'b1;
      step(1);
      check_time("mode_24h", 24'h130509);
      check_output("mode_24h_pm", 32'(pm), 32'd1);

      // Rollover chains
      apply_set(8'h23, 8'h59, 8'h58);
      step(4);
      check_time("roll_tick1", 24'h235959);
      step(4);
      check_time("roll_midnight", 24'h000000);
      check_output("roll_midnight_pm", 32'(pm), 32'd0);
      apply_set(8'h09, 8'h59, 8'h59);
      step(4);
      check_time("roll_hour", 24'h100000);

      // Rejected loads leave the time alone and pulse set_err once
      apply_set(8'h12, 8'h34, 8'h56);
      apply_set(8'h24, 8'h00, 8'h00);
      check_output("bad_hh_err", 32'(set_err), 32'd1);
      check_time("bad_hh_time", 24'h123456);
      step(1);
      check_output("bad_hh_err_fall", 32'(set_err), 32'd0);
      apply_set(8'h12, 8'h34, 8'h56);
      apply_set(8'h12, 8'h60, 8'h00);
      check_output("bad_mm_err", 32'(set_err), 32'd1);
      check_time("bad_mm_time", 24'h123456);
      step(1);
      check_output("bad_mm_err_fall", 32'(set_err), 32'd0);
      apply_set(8'h12, 8'h34, 8'h56);
      apply_set(8'h1A, 8'h00, 8'h00);
      check_output("bad_nib_err", 32'(set_err), 32'd1);
      check_time("bad_nib_time", 24'h123456);
      step(1);
      check_output("bad_nib_err_fall", 32'(set_err), 32'd0);

      // Invalid alarm write also flags set_err
      apply_alarm(2'd2, 8'h25, 8'h00, 1'b1);
      check_output("bad_alarm_err", 32'(set_err), 32'd1);
      step(1);
      check_output("bad_alarm_err_fall", 32'(set_err), 32'd0);

      // Two slots at 07:30: lowest index wins, stop ends the ring
      apply_alarm(2'd1, 8'h07, 8'h30, 1'b1);
      apply_alarm(2'd3, 8'h07, 8'h30, 1'b1);
      apply_set(8'h07, 8'h29, 8'h59);
      step(4);
      check_time("prio_time", 24'h073000);
      check_output("prio_not_yet", 32'(ringing), 32'd0);
      step(1);
      check_output("prio_ringing", 32'(ringing), 32'd1);
      check_output("prio_ring_id", 32'(ring_id), 32'd1);
      apply_ctrl(1'b1, 1'b0);
      check_output("prio_stop", 32'(ringing), 32'd0);

      // Loading the alarm time directly must not ring
      apply_set(8'h07, 8'h30, 8'h00);
      step(6);
      check_time("load_exact_time", 24'h073001);
      check_output("load_exact_quiet", 32'(ringing), 32'd0);

      // Snooze, re-ring after two minutes, timeout after one more
      apply_alarm(2'd2, 8'h06, 8'h00, 1'b1);
      apply_set(8'h05, 8'h59, 8'h59);
      step(4);
      check_time("snz_time", 24'h060000);
      step(1);
      check_output("snz_ringing", 32'(ringing), 32'd1);
      check_output("snz_ring_id", 32'(ring_id), 32'd2);
      apply_ctrl(1'b0, 1'b1);
      check_output("snz_quiet", 32'(ringing), 32'd0);
      step(478);
      check_time("snz_wake_time", 24'h060200);
      check_output("snz_wake_before", 32'(ringing), 32'd0);
      step(1);
      check_output("snz_wake_ringing", 32'(ringing), 32'd1);
      check_output("snz_wake_ring_id", 32'(ring_id), 32'd2);
      step(239);
      check_time("snz_timeout_time", 24'h060300);
      check_output("snz_timeout_before", 32'(ringing), 32'd1);
      step(1);
      check_output("snz_timeout", 32'(ringing), 32'd0);

      // Asynchronous reset while ringing
      apply_set(8'h05, 8'h59, 8'h59);
      step(5);
      check_output("arst_ringing", 32'(ringing), 32'd1);
      reset = 1'b0;
      #1;
      check_output("arst_ring_clear", 32'(ringing), 32'd0);
      check_time("arst_time", 24'h000000);
      @(negedge clock);
      reset = 1'b1;
      step(1);

      // stop together with snooze lands in IDLE, so no re-ring later
      apply_alarm(2'd0, 8'h06, 8'h00, 1'b1);
      apply_set(8'h05, 8'h59, 8'h59);
      step(5);
      check_output("both_ringing", 32'(ringing), 32'd1);
      check_output("both_ring_id", 32'(ring_id), 32'd0);
      apply_ctrl(1'b1, 1'b1);
      check_output("both_quiet", 32'(ringing), 32'd0);
      step(479);
      check_output("both_stays_idle", 32'(ringing), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/rtc_alarm_bank.md
# rtc_alarm_bank

Parametrised real-time clock core with a bank of programmable alarms. It keeps hh:mm:ss time internally in 24-hour BCD from an internal prescaler and presents either a 12-hour or 24-hour display. Up to NUM_ALARMS alarms are compared on each minute boundary, and a ring/snooze/stop state machine drives the alarm output. It sits between the board clock and the display/buzzer drivers, and is the successor of the fixed 12-hour, single-alarm clock.

## Interface
- TICK_DIV, 100_000_000: clock cycles per second; ≥2.
- NUM_ALARMS, 4: number of alarm slots; 1..16.
- SNOOZE_MIN, 5: snooze length in minutes; 1..59.
- RING_MIN, 2: auto-stop after this many minutes of ringing; 1..59.
- clock  in  1  single system clock; all logic rising-edge.
- reset  in  1  asynchronous, active-low reset.
- mode_24h  in  1  1 = 24-hour display; 0 = 12-hour display.
- set_valid  in  1  one-cycle strobe that loads the time.
- set_hh, set_mm, set_ss  in  8 each  BCD time to load, always in 24-hour form.
- set_err  out  1  one-cycle pulse when a load is rejected.
- alm_wr  in  1  one-cycle strobe that writes an alarm slot.
- alm_idx  in  $clog2(NUM_ALARMS) (min 1)  slot number to write.
- alm_hh, alm_mm  in  8 each  BCD alarm time, 24-hour form.
- alm_en  in  1  enable bit written into the slot.
- snooze  in  1  one-cycle request to snooze.
- stop  in  1  one-cycle request to stop.
- h_tens, h_ones, m_tens, m_ones, s_tens, s_ones  out  4 each  display BCD digits.
- pm  out  1  1 when internal hour ≥ 12, valid in both display modes.
- ringing  out  1  alarm sounding.
- ring_id  out  $clog2(NUM_ALARMS)  slot that caused the current ring or snooze.

## Operation
- **Reset.** All of the following reset to 0: time (00:00:00), prescaler, all alarm slots (disabled, 00:00), FSM (IDLE), ringing, ring_id, set_err, pm.
  - Display after reset: 24-hour mode shows 00:00:00; 12-hour mode shows 12:00:00.
- **Timebase.**
  - Prescaler counts 0..TICK_DIV-1.
  - At terminal count: seconds advance and the prescaler wraps to 0.
  - Rollover chain: ss 59→00 carries to mm; mm 59→00 carries to hh; hh 23→00.
- **Time load.**
  - A valid set_valid load replaces the time and clears the prescaler.
  - Set has priority over a coincident tick.
  - Load is rejected if any nibble is >9, hh>23, mm>59 or ss>59. On rejection: time is unchanged and set_err pulses for 1 cycle.
- **Alarm write.**
  - alm_wr writes hh, mm and en into slot alm_idx.
  - alm_idx ≥ NUM_ALARMS is ignored.
  - Invalid BCD clears the slot's enable bit and pulses set_err.
- **Match.**
  - Evaluated only on a tick that produces ss=00.
  - A slot matches when it is enabled and its hh:mm equals the new hh:mm.
  - Loading the time via set_valid never causes a match.
  - If several slots match, the lowest index wins.
- **FSM states and transitions.**
  - IDLE → RING on match; latch ring_id and clear the minute counter.
  - RING → IDLE on stop.
  - RING → SNOOZE on snooze; clear the minute counter.
  - RING → IDLE after RING_MIN minute rollovers.
  - RING ignores new matches.
  - SNOOZE → RING after SNOOZE_MIN minute rollovers; ring_id is kept.
  - SNOOZE → IDLE on stop.
  - SNOOZE → RING on a match from any slot; ring_id becomes the matching slot.
  - If stop and snooze arrive together, stop wins.
  - A set_valid load does not change the FSM state.
- **12-hour display mapping.**
  - Internal hour 0 → 12 with pm=0.
  - Internal hours 1–11 → unchanged, pm=0.
  - Internal hour 12 → 12 with pm=1.
  - Internal hours 13–23 → hour−12, pm=1.
  - mode_24h only affects the display; it can change at any time without disturbing the time.

## Timing
- All outputs are registered.
- **Time advance:** the digits change on the clock edge at prescaler terminal count.
- **Load:** digits show the loaded time 1 cycle after set_valid.
  - The first tick after a load comes TICK_DIV cycles later.
- **ringing rise:** 1 cycle after the digits show hh:mm:00.
- **ringing fall:** 1 cycle after stop, snooze or timeout.
- **set_err:** 1 cycle after the offending strobe; high for exactly 1 cycle.
- **Alarm write:** takes effect on the next cycle; a write coincident with the matching tick uses the old slot contents.
- **Asynchronous reset:** asserting reset mid-operation clears everything immediately. Deassertion is synchronised externally.

## Structure
- **Package `rtc_pkg`:**
  - FSM state enum {IDLE, RING, SNOOZE};
  - bcd8_t;
  - constants MAX_HH=8'h23 and MAX_MS=8'h59;
  - function `bcd_valid(val, max)`;
  - function `to12h(hh) → {hh12, pm}`.
- **Sub-module `rtc_alarm_fsm`:** takes match/stop/snooze/minute-tick inputs and produces ringing and ring_id.
- The timebase, the alarm slot array and the display mapping live in the top module.

## Test plan
Use TICK_DIV=4, NUM_ALARMS=4, SNOOZE_MIN=2, RING_MIN=1.
- **Reset/display:** reset, mode_24h=0 → 12:00:00 with pm=0. Load 13:05:09 → 01:05:09 with pm=1. Switch to mode_24h=1 → 13:05:09.
- **Rollover:** load 23:59:58, wait 2 ticks → 00:00:00 with pm=0. Load 09:59:59, wait 1 tick → 10:00:00.
- **Invalid load:** set 24:00:00, then 12:60:00, then 8'h1A:00:00 → set_err pulses each time and the time is unchanged.
- **Alarm priority:** slots 1 and 3 both at 07:30 and enabled; load 07:29:59; 1 tick → ringing=1 one cycle later with ring_id=1. stop → ringing=0 one cycle later.
- **Snooze:** ringing at 06:00; snooze at 06:00:10 → ringing=0. Ring again at 06:02:00 with the same ring_id. No further action → ringing=0 at 06:03:00 (RING_MIN timeout).
- **Corner cases:**
  - Load 07:30:00 exactly with an alarm at 07:30 → no ring.
  - Reset asserted while RING → ringing=0 immediately.
  - stop and snooze in the same cycle → IDLE.
